// File: rtl/mram_pkg.sv
// MRAM burst sequencer shared definitions:
// default geometry, timing, FSM encodings.
package mram_pkg;

    localparam int ADDR_W_D  = 20;
    localparam int DATA_W_D  = 16;
    localparam int LEN_W_D   = 8;
    localparam int T_SETUP_D = 1;
    localparam int T_PULSE_D = 4;
    localparam int T_HOLD_D  = 1;
    localparam int T_TURN_D  = 1;
    localparam int TMR_W     = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WDAT  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_TURN  = 3'd5;

    // An empty byte mask means a full-word access.
    function automatic logic [1:0] eff_be(input logic [1:0] be);
        return (be == 2'b00) ? 2'b11 : be;
    endfunction

endpackage

// File: rtl/mram_phase_timer.sv
// Loadable phase down-counter; tc is high
// while the count sits at zero.
module mram_phase_timer
    import mram_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mram_burst_sequencer.sv
// Single/burst access sequencer for the async
// SRAM-style MRAM bus with programmable timing.
module mram_burst_sequencer
    import mram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int LEN_W   = LEN_W_D,
    parameter int T_SETUP = T_SETUP_D,
    parameter int T_PULSE = T_PULSE_D,
    parameter int T_HOLD  = T_HOLD_D,
    parameter int T_TURN  = T_TURN_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [1:0]        cmd_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] dq_i,
    output logic [DATA_W-1:0] dq_o,
    output logic              dq_oe,
    output logic [ADDR_W-1:0] addr_to_MRAM,
    output logic              chip_en,
    output logic              write_en,
    output logic              out_en,
    output logic              lower_byte_en,
    output logic              upper_byte_en
);

    logic [2:0]        state, state_nxt;
    logic              tmr_load, tmr_tc;
    logic [TMR_W-1:0]  tmr_val;
    logic              wr_cmd;
    logic [1:0]        be_q;
    logic [LEN_W-1:0]  beats_q;
    logic [ADDR_W-1:0] addr_q;
    logic              accept, last_beat;
    logic              c_write;
    logic [1:0]        c_be;
    logic [ADDR_W-1:0] c_addr;
    logic              ent_setup, ent_pulse;
    logic              ent_hold, ent_turn, ent_wdat;

    mram_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign wr_ready  = (state == S_WDAT);
    assign done      = (state == S_TURN) && tmr_tc;
    assign accept    = cmd_ready && cmd_valid;
    assign last_beat = (beats_q == '0);

    // A read goes straight to SETUP on the accept edge, before fields are latched.
    assign c_write = accept ? cmd_write : wr_cmd;
    assign c_be    = accept ? eff_be(cmd_be) : be_q;
    assign c_addr  = accept ? cmd_addr : addr_q;

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        state_nxt = S_WDAT;
                    end else begin
                        state_nxt = S_SETUP;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(T_SETUP - 1);
                    end
                end
            end
            S_WDAT: begin
                if (wr_valid) begin
                    state_nxt = S_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(T_SETUP - 1);
                end
            end
            S_SETUP: begin
                if (tmr_tc) begin
                    state_nxt = S_PULSE;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(T_PULSE - 1);
                end
            end
            S_PULSE: begin
                if (tmr_tc) begin
                    state_nxt = S_HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(T_HOLD - 1);
                end
            end
            S_HOLD: begin
                if (tmr_tc) begin
                    if (last_beat) begin
                        state_nxt = S_TURN;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(T_TURN - 1);
                    end else if (wr_cmd) begin
                        state_nxt = S_WDAT;
                    end else begin
                        state_nxt = S_SETUP;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(T_SETUP - 1);
                    end
                end
            end
            S_TURN: begin
                if (tmr_tc) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ent_setup = (state_nxt == S_SETUP) && (state != S_SETUP);
    assign ent_pulse = (state_nxt == S_PULSE) && (state != S_PULSE);
    assign ent_hold  = (state_nxt == S_HOLD) && (state != S_HOLD);
    assign ent_turn  = (state_nxt == S_TURN) && (state != S_TURN);
    assign ent_wdat  = (state == S_HOLD) && (state_nxt == S_WDAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            wr_cmd        <= 1'b0;
            be_q          <= 2'b11;
            beats_q       <= '0;
            addr_q        <= '0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            dq_o          <= '0;
            dq_oe         <= 1'b0;
            addr_to_MRAM  <= '0;
            chip_en       <= 1'b1;
            write_en      <= 1'b1;
            out_en        <= 1'b1;
            lower_byte_en <= 1'b1;
            upper_byte_en <= 1'b1;
        end else begin
            state    <= state_nxt;
            rd_valid <= 1'b0;
            if (accept) begin
                wr_cmd  <= cmd_write;
                be_q    <= eff_be(cmd_be);
                beats_q <= cmd_len;
                addr_q  <= cmd_addr;
            end
            if (wr_ready && wr_valid) begin
                dq_o <= wr_data;
            end
            // addr_q always holds the address of the next beat.
            if (ent_setup) begin
                chip_en       <= 1'b0;
                addr_to_MRAM  <= c_addr;
                addr_q        <= c_addr + ADDR_W'(1);
                lower_byte_en <= ~c_be[0];
                upper_byte_en <= ~c_be[1];
                dq_oe         <= c_write;
            end
            if (ent_pulse) begin
                write_en <= ~wr_cmd;
                out_en   <= wr_cmd;
            end
            if (ent_hold) begin
                write_en <= 1'b1;
                out_en   <= 1'b1;
                if (!wr_cmd) begin
                    rd_valid <= 1'b1;
                    rd_data  <= dq_i;
                end
            end
            if (state == S_HOLD && tmr_tc && !last_beat) begin
                beats_q <= beats_q - 1'b1;
            end
            if (ent_wdat) begin
                dq_oe <= 1'b0;
            end
            if (ent_turn) begin
                chip_en       <= 1'b1;
                lower_byte_en <= 1'b1;
                upper_byte_en <= 1'b1;
                dq_oe         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mram_burst_sequencer.sv
// Bench for mram_burst_sequencer: directed table,
// random commands vs. a word-level MRAM model.
module tb_mram_burst_sequencer;

    localparam int TS = 1;
    localparam int TP = 4;
    localparam int TH = 1;
    localparam int TT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [19:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_be;
    logic [15:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, busy, done;
    logic [15:0] dq_i, dq_o;
    logic        dq_oe;
    logic [19:0] addr_to_MRAM;
    logic        chip_en, write_en, out_en;
    logic        lower_byte_en, upper_byte_en;

    always #5 clk = ~clk;

    mram_burst_sequencer #(
        .ADDR_W(20), .DATA_W(16), .LEN_W(8),
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_TURN(TT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_be(cmd_be),
        .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done),
        .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe),
        .addr_to_MRAM(addr_to_MRAM), .chip_en(chip_en),
        .write_en(write_en), .out_en(out_en),
        .lower_byte_en(lower_byte_en),
        .upper_byte_en(upper_byte_en)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // MRAM device behind the pins, and the bench's own expectation of it
    logic [15:0] mem [bit [19:0]];
    logic [15:0] ref_mem [bit [19:0]];

    function automatic logic [15:0] init_word(input logic [19:0] a);
        return {a[7:0] ^ 8'h3C, a[15:8] + {4'h0, a[19:16]}};
    endfunction

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [1:0] tb_be(input logic [1:0] be);
        return (be == 2'b00) ? 2'b11 : be;
    endfunction

    always @(negedge clk) begin
        if (!chip_en && !out_en) dq_i <= mem_rd(addr_to_MRAM);
        else dq_i <= 16'hBEEF;
    end

    always @(posedge write_en) begin
        logic [15:0] w;
        if (rst && !chip_en && dq_oe) begin
            w = mem_rd(addr_to_MRAM);
            if (!lower_byte_en) w[7:0] = dq_o[7:0];
            if (!upper_byte_en) w[15:8] = dq_o[15:8];
            mem[addr_to_MRAM] = w;
        end
    end

    // bus monitor
    int ce_low, done_cnt, acc_cnt, viol, stall_cnt;
    int we_run, oe_run;
    int we_runs[$], oe_runs[$];
    logic [19:0] addrs[$];
    logic [1:0]  bens[$];
    logic [15:0] rdq[$];

    task automatic clear_mon();
        ce_low = 0; done_cnt = 0; acc_cnt = 0;
        viol = 0; stall_cnt = 0; we_run = 0; oe_run = 0;
        we_runs.delete(); oe_runs.delete();
        addrs.delete(); bens.delete(); rdq.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (!chip_en) ce_low++;
            if (done) done_cnt++;
            if (cmd_valid && cmd_ready) acc_cnt++;
            if (dq_oe && (chip_en || !out_en)) viol++;
            if (wr_ready && !wr_valid) stall_cnt++;
            if (rd_valid) rdq.push_back(rd_data);
            if (!write_en || !out_en) begin
                if (we_run == 0 && oe_run == 0) begin
                    addrs.push_back(addr_to_MRAM);
                    bens.push_back({upper_byte_en, lower_byte_en});
                end
            end
            if (!write_en) we_run++;
            else if (we_run > 0) begin
                we_runs.push_back(we_run); we_run = 0;
            end
            if (!out_en) oe_run++;
            else if (oe_run > 0) begin
                oe_runs.push_back(oe_run); oe_run = 0;
            end
        end
    end

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [19:0] addr;
        int          len;
        logic [1:0]  be;
        logic [15:0] base;
        int          sb;
        int          sc;
        bit          poke;
        int          exp_ce;
        logic [1:0]  exp_ben;
        int          exp_stall;
    } vec_t;

    task automatic run_cmd(input vec_t v, input bit rnd);
        logic [15:0] d[$];
        logic [19:0] ai;
        logic [15:0] w;
        logic [1:0]  eb;
        int beats, i, g, left;
        beats = v.len + 1;
        eb = tb_be(v.be);
        for (int k = 0; k < beats; k++)
            d.push_back(rnd ? 16'($urandom) : v.base ^ 16'(k * 16'h1111));
        if (v.wr) begin
            for (int k = 0; k < beats; k++) begin
                ai = v.addr + 20'(k);
                w = ref_rd(ai);
                if (eb[0]) w[7:0] = d[k][7:0];
                if (eb[1]) w[15:8] = d[k][15:8];
                ref_mem[ai] = w;
            end
        end
        @(posedge clk); #1;
        clear_mon();
        cmd_write = v.wr; cmd_addr = v.addr;
        cmd_len = 8'(v.len); cmd_be = v.be; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (v.poke) begin
            cmd_valid = 1'b1; cmd_write = ~v.wr;
            repeat (8) @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
        if (v.wr) begin
            i = 0; g = 0; left = v.sc;
            while (i < beats && g < 2000) begin
                wr_valid = 1'b0;
                if (wr_ready) begin
                    if (i == v.sb && left > 0) left--;
                    else begin
                        wr_valid = 1'b1; wr_data = d[i]; i++;
                    end
                end
                @(posedge clk); #1; g++;
            end
            wr_valid = 1'b0;
            check("wr_supply_timeout", 32'(g < 2000), 1);
        end
        g = 0;
        while (done_cnt == 0 && g < 3000) begin
            @(negedge clk); g++;
        end
        check("done_timeout", 32'(g < 3000), 1);
        repeat (2) @(negedge clk);
        check("accept_cnt", acc_cnt, 1);
        check("done_cnt", done_cnt, 1);
        check("ce_low_cycles", ce_low, v.exp_ce);
        check("dq_oe_viol", viol, 0);
        check("cmd_ready_after", 32'(cmd_ready), 1);
        if (v.wr) begin
            check("stall_cycles", stall_cnt, v.exp_stall);
            check("we_pulses", we_runs.size(), beats);
            check("oe_pulses_wr", oe_runs.size(), 0);
            foreach (we_runs[k]) check("we_width", we_runs[k], TP);
        end else begin
            check("oe_pulses", oe_runs.size(), beats);
            check("we_pulses_rd", we_runs.size(), 0);
            check("rd_valid_cnt", rdq.size(), beats);
            foreach (oe_runs[k]) check("oe_width", oe_runs[k], TP);
        end
        check("beat_addr_cnt", addrs.size(), beats);
        foreach (addrs[k]) begin
            ai = v.addr + 20'(k);
            check("beat_addr", 32'(addrs[k]), 32'(ai));
            check("byte_en_n", 32'(bens[k]), 32'(v.exp_ben));
            if (v.wr) check("mem_word", mem_rd(ai), ref_rd(ai));
            else if (k < rdq.size()) check("rd_data", rdq[k], ref_rd(ai));
        end
    endtask

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int g;
        tbl[0] = '{1'b1, 20'h00010, 0, 2'b11, 16'hA5A5, 0, 0, 1'b0, 6, 2'b00, 0};
        tbl[1] = '{1'b0, 20'h00100, 3, 2'b11, 16'h0, 0, 0, 1'b1, 24, 2'b00, 0};
        tbl[2] = '{1'b0, 20'hFFFFE, 3, 2'b11, 16'h0, 0, 0, 1'b0, 24, 2'b00, 0};
        tbl[3] = '{1'b1, 20'h00300, 1, 2'b11, 16'h1357, 1, 5, 1'b0, 18, 2'b00, 5};
        tbl[4] = '{1'b1, 20'h00010, 0, 2'b01, 16'h3C3C, 0, 0, 1'b0, 6, 2'b10, 0};
        tbl[5] = '{1'b0, 20'h00010, 0, 2'b00, 16'h0, 0, 0, 1'b0, 6, 2'b00, 0};
        tbl[6] = '{1'b0, 20'h00300, 1, 2'b10, 16'h0, 0, 0, 1'b0, 12, 2'b01, 0};

        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_len = '0; cmd_be = '0;
        wr_data = '0; wr_valid = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce_n", 32'(chip_en), 1);
        check("rst_we_n", 32'(write_en), 1);
        check("rst_oe_n", 32'(out_en), 1);
        check("rst_lb_ub_n", 32'({upper_byte_en, lower_byte_en}), 3);
        check("rst_addr", 32'(addr_to_MRAM), 0);
        check("rst_dq_o", 32'(dq_o), 0);
        check("rst_dq_oe", 32'(dq_oe), 0);
        check("rst_flags", 32'({rd_valid, done, busy, wr_ready}), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        #3 rst = 1'b1;

        foreach (tbl[k]) run_cmd(tbl[k], 1'b0);

        for (int n = 0; n < 20; n++) begin
            v.wr   = 1'($urandom_range(0, 1));
            v.addr = ($urandom_range(0, 3) == 0)
                     ? 20'hFFFFF - 20'($urandom_range(0, 4))
                     : 20'($urandom);
            v.len  = $urandom_range(0, 7);
            v.be   = 2'($urandom_range(0, 3));
            v.base = '0;
            v.sb   = $urandom_range(0, v.len);
            v.sc   = $urandom_range(0, 3);
            v.poke = 1'b0;
            v.exp_ben = ~tb_be(v.be);
            v.exp_stall = v.wr ? v.sc : 0;
            v.exp_ce = (v.len + 1) * (TS + TP + TH);
            if (v.wr) v.exp_ce += v.len + ((v.sb > 0) ? v.sc : 0);
            run_cmd(v, 1'b1);
        end

        // async reset in the middle of a write strobe
        @(posedge clk); #1;
        clear_mon();
        wr_valid = 1'b1; wr_data = 16'h1234;
        cmd_write = 1'b1; cmd_addr = 20'h00200;
        cmd_len = 8'd7; cmd_be = 2'b11; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        g = 0;
        while (write_en && g < 200) begin
            @(posedge clk); #1; g++;
        end
        check("mid_pulse_reached", 32'(write_en), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("arst_we_n", 32'(write_en), 1);
        check("arst_ce_n", 32'(chip_en), 1);
        check("arst_oe_n", 32'(out_en), 1);
        check("arst_dq_oe", 32'(dq_oe), 0);
        check("arst_lb_ub_n", 32'({upper_byte_en, lower_byte_en}), 3);
        check("arst_busy", 32'(busy), 0);
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_no_done", done_cnt, 0);
        check("arst_cmd_ready", 32'(cmd_ready), 1);
        check("arst_idle_ce_n", 32'(chip_en), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
